imem_loader: RTL and testbench

Byte-stream boot loader that writes a program image into the byte-wide, little-endian instruction memory of `mips_single` and holds the CPU in reset until the image is complete. It takes a length-prefixed byte stream over a valid/ready handshake and issues one memory byte write per accepted payload byte. It then releases `cpu_rst` so that the CPU begins fetching at PC 0. It lets hardware load memory contents that the simulation flow otherwise preloads with `$readmemh`.

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream boot loader for the mips_single instruction memory.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_cnt
);

`ifdef IMEM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_FIN, S_DONE, S_ERR
  } state_t;
  localparam state_t S_POST = S_CHK;
`else
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_FIN, S_DONE, S_ERR
  } state_t;
  localparam state_t S_POST = S_FIN;
`endif

  localparam logic [16:0]     CAP = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic              w_ready_state;
  logic              w_acc;
  logic [16:0]       w_len;
  logic [ADDR_W:0]   w_cnt_inc;

  always_comb begin
    w_ready_state = 1'b0;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA: w_ready_state = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
      S_CHK:                      w_ready_state = 1'b1;
`endif
      default:                    w_ready_state = 1'b0;
    endcase
  end

  // Ready is gated combinationally so a byte presented alongside reload is never accepted.
  assign in_ready  = w_ready_state & ~reload & rst;
  assign w_acc     = in_valid & in_ready;
  assign w_len     = {1'b0, in_data, r_len_lo};
  assign w_cnt_inc = r_cnt + ONE;
  assign load_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_LEN_LO;
      r_len_lo  <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (reload) begin
        r_state <= S_LEN_LO;
        r_cnt   <= '0;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
        r_sum   <= '0;
`endif
      end else begin
        case (r_state)
          S_LEN_LO: if (w_acc) begin
            r_len_lo <= in_data;
            r_state  <= S_LEN_HI;
          end
          S_LEN_HI: if (w_acc) begin
            if (w_len > CAP) begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end else begin
              r_len   <= w_len[ADDR_W:0];
              r_state <= (w_len == '0) ? S_POST : S_DATA;
            end
          end
          S_DATA: if (w_acc) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_cnt[ADDR_W-1:0];
            mem_wdata <= in_data;
            r_cnt     <= w_cnt_inc;
`ifdef IMEM_LOADER_CHKSUM_EN
            r_sum     <= r_sum + in_data;
`endif
            if (w_cnt_inc == r_len) r_state <= S_POST;
          end
`ifdef IMEM_LOADER_CHKSUM_EN
          S_CHK: if (w_acc) begin
            if (in_data == r_sum) begin
              r_state <= S_FIN;
            end else begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end
          end
`endif
          S_FIN: begin
            r_state <= S_DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=10); follows IMEM_LOADER_CHKSUM_EN if defined.
module tb_imem_loader;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [AW:0]   load_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_n    = 0;
  int wr_addr [0:2047];
  int wr_data [0:2047];
  int wr_cyc  [0:2047];
  logic [7:0] prog [0:7];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .err(err), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (mem_we && wr_n < 2048) begin
      wr_addr[wr_n] = int'(mem_addr);
      wr_data[wr_n] = int'(mem_wdata);
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one byte and returns #1 after the edge that accepts it.
  task automatic send(input logic [7:0] b, input bit gap);
    int wait_n;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    wait_n   = 0;
    while (!in_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    wr_n   = 0;
  endtask

  task automatic send_prog(input bit gap);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) send(prog[i], gap);
`ifdef IMEM_LOADER_CHKSUM_EN
    send(8'h67, 1'b0);
`endif
  endtask

  task automatic check_prog(input string tag, input int spacing);
    chk({tag, "_nwr"}, 32'(wr_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
      chk({tag, "_data"}, 32'(wr_data[i]), 32'(prog[i]));
      if (i > 0) chk({tag, "_spacing"}, 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(spacing));
    end
  endtask

  initial begin
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h20; prog[5] = 8'h10; prog[6] = 8'h00; prog[7] = 8'h0A;
    rst = 1'b0; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset values
    #12;
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_load_cnt",  32'(load_cnt),  32'd0);
    chk("rst_cpu_rst",   32'(cpu_rst),   32'd1);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Normal load, continuous valid
    send_prog(1'b0);
`ifndef IMEM_LOADER_CHKSUM_EN
    chk("norm_last_we",   32'(mem_we),   32'd1);
    chk("norm_last_addr", 32'(mem_addr), 32'd7);
`endif
    chk("norm_fin_done",    32'(done),    32'd0);
    chk("norm_fin_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("norm_fin_ready",   32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("norm_done",     32'(done),     32'd1);
    chk("norm_cpu_rst",  32'(cpu_rst),  32'd0);
    chk("norm_load_cnt", 32'(load_cnt), 32'd8);
    chk("norm_ready",    32'(in_ready), 32'd0);
    chk("norm_we_off",   32'(mem_we),   32'd0);
    check_prog("norm", 1);

    // Reload from DONE, then gapped stream
    pulse_reload();
    chk("rl_done",     32'(done),     32'd0);
    chk("rl_cpu_rst",  32'(cpu_rst),  32'd1);
    chk("rl_load_cnt", 32'(load_cnt), 32'd0);
    send_prog(1'b1);
    @(posedge clk); #1;
    chk("gap_done",     32'(done),     32'd1);
    chk("gap_load_cnt", 32'(load_cnt), 32'd8);
    check_prog("gap", 2);

    // Zero length
    pulse_reload();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHKSUM_EN
    send(8'h00, 1'b0);
`endif
    chk("zero_fin_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("zero_done",    32'(done),    32'd1);
    chk("zero_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("zero_nwr",     32'(wr_n),    32'd0);

    // Capacity boundary: LEN = 0x400
    pulse_reload();
    begin
      logic [7:0] sum;
      sum = 8'h00;
      send(8'h00, 1'b0);
      send(8'h04, 1'b0);
      for (int i = 0; i < 1024; i++) begin
        send(8'(i) ^ 8'h5A, 1'b0);
        sum = sum + (8'(i) ^ 8'h5A);
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      send(sum, 1'b0);
`endif
    end
    @(posedge clk); #1;
    chk("cap_nwr",       32'(wr_n),           32'd1024);
    chk("cap_last_addr", 32'(wr_addr[1023]),  32'h3FF);
    chk("cap_last_data", 32'(wr_data[1023]),  32'hA5);
    chk("cap_load_cnt",  32'(load_cnt),       32'h400);
    chk("cap_done",      32'(done),           32'd1);

    // Oversize: LEN = 0x401
    pulse_reload();
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    chk("ovr_err",     32'(err),      32'd1);
    chk("ovr_ready",   32'(in_ready), 32'd0);
    chk("ovr_cpu_rst", 32'(cpu_rst),  32'd1);
    @(posedge clk); #1;
    chk("ovr_err_hold", 32'(err),  32'd1);
    chk("ovr_done",     32'(done), 32'd0);
    chk("ovr_nwr",      32'(wr_n), 32'd0);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Bad checksum
    pulse_reload();
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) send(prog[i], 1'b0);
    send(8'h00, 1'b0);
    chk("cks_err",  32'(err),  32'd1);
    chk("cks_done", 32'(done), 32'd0);
    chk("cks_nwr",  32'(wr_n), 32'd8);
`endif

    // Reload during a valid payload byte
    pulse_reload();
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    send(8'h20, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    reload   = 1'b1;
    #1;
    chk("rlm_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rlm_we",       32'(mem_we),   32'd0);
    chk("rlm_load_cnt", 32'(load_cnt), 32'd0);
    reload   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rlm_ready", 32'(in_ready), 32'd1);
    wr_n = 0;
    send_prog(1'b0);
    @(posedge clk); #1;
    chk("rlm_done", 32'(done), 32'd1);
    check_prog("rlm", 1);

    // Async reset mid-DATA
    pulse_reload();
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_we",       32'(mem_we),    32'd0);
    chk("arst_addr",     32'(mem_addr),  32'd0);
    chk("arst_wdata",    32'(mem_wdata), 32'd0);
    chk("arst_load_cnt", 32'(load_cnt),  32'd0);
    chk("arst_cpu_rst",  32'(cpu_rst),   32'd1);
    chk("arst_ready",    32'(in_ready),  32'd0);
    @(negedge clk);
    rst  = 1'b1;
    wr_n = 0;
    send_prog(1'b0);
    @(posedge clk); #1;
    chk("arst_done", 32'(done), 32'd1);
    check_prog("arst", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
